shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter and sequencer for a single shared W-bit enabled data register written by N requesters. Each requester raises a request with its write data. The block grants exactly one requester at a time and drives the shared register's enable and data mux from the grant. Ownership is bounded by a hold limit, so no requester can starve the others. The block sits between the requesting datapath units and the shared storage register, and owns that register internally.

## Interface
- N, default 4: number of requesters, 2..16.
- W, default 8: register data width.
- MAX_HOLD, default 4: maximum write cycles per grant, 1..255.

Ports:
- clk  in  1: single clock, rising-edge.
- reset  in  1: asynchronous, active-low reset. Asserting it (low) clears all state immediately.
- req  in  N: per-requester request; req[i] is held high while requester i wants to write.
- wdata  in  N*W: concatenated write data; slice i is wdata[i*W +: W].
- gnt  out  N: registered one-hot grant; all zero when no owner.
- q  out  W: shared register contents.
- busy  out  1: high when state is not IDLE.
- owner  out  clog2(N): index of the last granted requester.

## Operation
- States: IDLE, GRANT, RELEASE. busy = (state != IDLE).
- Reset values: state=IDLE, gnt=0, q=0, busy=0, owner=N-1 (so the first search starts at requester 0), hold counter=0.
- IDLE:
  - If any req bit is high, search from owner+1 upward, modulo N. Pick the first i with req[i]=1.
  - Register gnt = one-hot(i), owner=i, counter=0, and go to GRANT.
  - If req=0, stay in IDLE with gnt=0.
- GRANT, with owner i:
  - On each edge where req[i]=1: q <= wdata slice i, counter+1.
  - If the incremented counter equals MAX_HOLD: gnt <= 0, go to RELEASE.
  - Otherwise stay in GRANT.
  - On an edge where req[i]=0: no write, gnt <= 0, go to RELEASE.
- RELEASE: one dead cycle with gnt=0 and no write, then go to IDLE. IDLE arbitrates on the following edge.
- q changes only on an edge where gnt[i]=1 and req[i]=1. Otherwise q holds its value, matching enable-register semantics.
- Requests from non-owners are ignored during GRANT and RELEASE. Only the state at the IDLE edge matters for arbitration.
- Counter width is clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.
- Pointer wrap: after owner N-1, the search continues at 0.
- Reset going low mid-GRANT: gnt and q clear asynchronously in the same cycle, and state returns to IDLE. There is no partial write.
- When reset is released, the first arbitration occurs on the first rising edge with reset high.

## Timing
- Request-to-grant latency: req sampled high at IDLE edge k gives gnt high after edge k.
- First write lands in q at edge k+1.
- Full burst: a requester holding req gets exactly MAX_HOLD writes, at edges k+1..k+MAX_HOLD. gnt falls after edge k+MAX_HOLD.
- Release timing: RELEASE occupies edge k+MAX_HOLD+1, IDLE arbitrates at edge k+MAX_HOLD+2, and the next gnt is high after that edge.
- Minimum back-to-back gap between two grants is 2 cycles of gnt=0.
- Worst-case wait for a continuously requesting requester is (N-1)*(MAX_HOLD+2) cycles, plus up to MAX_HOLD+2 cycles if a grant is in progress.
- All outputs are registered or derived only from state. There is no combinational path from req or wdata to any output.

## Test plan
- Reset: hold reset low with random req.
  - Expect gnt=0, q=0, busy=0, owner=N-1.
  - Release reset with req=4'b0001: expect gnt=4'b0001 after the first edge.
- Single burst: N=4, MAX_HOLD=4, req[2] held high, wdata slice 2 = 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 on successive cycles.
  - Expect q to take 8'h11..8'h44.
  - Expect gnt low after the 4th write and q to stay 8'h44.
- Early release: req[1] high for 2 cycles after grant, then low.
  - Expect exactly 2 writes, gnt low one edge later, RELEASE, then IDLE.
- Round-robin fairness: req=4'b1111 held, owner=N-1 after reset.
  - Expect grant order 0, 1, 2, 3, 0.
  - Expect each grant to last MAX_HOLD writes with 2-cycle gaps between grants.
- Wrap and skip: owner=2 (left by a preceding grant to requester 2), then req=4'b0011.
  - Expect requester 0 granted first, then requester 1.
- Reset mid-burst: drive reset low during the 2nd GRANT cycle.
  - Expect gnt=0 and q=0 immediately.
  - After reset is released with req still high, expect the grant to restart from requester 0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that owns a shared W-bit enabled register written by N requesters.
// Each grant is bounded to MAX_HOLD writes and is followed by one RELEASE cycle before the next arbitration.
module shared_reg_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int          OW = $clog2(N);
    localparam int          CW = $clog2(MAX_HOLD + 1);
    localparam int unsigned NU = N;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [W-1:0]    q_q, q_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic            found;
    logic [OW-1:0]   pick;
    logic [OW-1:0]   cand;

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = owner_q;
        cand  = owner_q;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand = OW'((32'(owner_q) + k) % NU);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (found) begin
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (req[owner_q]) begin
                    q_d   = wdata[32'(owner_q) * W +: W];
                    cnt_d = cnt_inc;
                    if (cnt_inc == HOLD_LAST) begin
                        gnt_d   = '0;
                        state_d = RELEASE;
                    end
                end else begin
                    gnt_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= OW'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = q_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=4): vector table plus
// hand-built round-robin and mid-burst reset sequences, all checked through a scoreboard queue.
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;
    logic [1:0]  owner;

    vec_t sb[$];
    vec_t tbl[21];
    int   n_vec;
    int   n_bad;

    shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                                input logic [3:0] g, input logic [7:0] qq, input logic b,
                                input logic [1:0] o);
        vec_t v;
        v.rst = r; v.req = rq; v.wdata = wd;
        v.gnt = g; v.q = qq; v.busy = b; v.owner = o;
        return v;
    endfunction

    function automatic logic [31:0] rr_data(input int unsigned c);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = {4'(i), 4'(c)};
        return d;
    endfunction

    task automatic check_out(input string name);
        vec_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: scoreboard empty, no expected value available", name);
        end else begin
            e = sb.pop_front();
            if (gnt !== e.gnt || q !== e.q || busy !== e.busy || owner !== e.owner) begin
                n_bad++;
                $display("FAIL %s: got gnt=%b q=%h busy=%b owner=%0d, want gnt=%b q=%h busy=%b owner=%0d",
                         name, gnt, q, busy, owner, e.gnt, e.q, e.busy, e.owner);
            end
        end
    endtask

    task automatic step(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst;
        req   = v.req;
        wdata = v.wdata;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  order [5];
        logic [1:0]  g;
        logic [3:0]  oh;
        logic [7:0]  qexp;
        logic [31:0] d;
        int unsigned cyc;

        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        req   = '0;
        wdata = '0;

        // reset, first grant, single burst on req[2], wrap/skip to 0 then 1, early releases
        tbl[0]  = mk(0, 4'b1010, 32'h0000_0000, 4'b0000, 8'h00, 0, 2'd3);
        tbl[1]  = mk(0, 4'b1111, 32'hFFFF_FFFF, 4'b0000, 8'h00, 0, 2'd3);
        tbl[2]  = mk(1, 4'b0001, 32'h0000_00A1, 4'b0001, 8'h00, 1, 2'd0);
        tbl[3]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 1, 2'd0);
        tbl[4]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 0, 2'd0);
        tbl[5]  = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h00, 0, 2'd0);
        tbl[6]  = mk(1, 4'b0100, 32'h00EE_0000, 4'b0100, 8'h00, 1, 2'd2);
        tbl[7]  = mk(1, 4'b0100, 32'h5511_6677, 4'b0100, 8'h11, 1, 2'd2);
        tbl[8]  = mk(1, 4'b0100, 32'h0022_0000, 4'b0100, 8'h22, 1, 2'd2);
        tbl[9]  = mk(1, 4'b0100, 32'h0033_0000, 4'b0100, 8'h33, 1, 2'd2);
        tbl[10] = mk(1, 4'b0100, 32'h0044_0000, 4'b0000, 8'h44, 1, 2'd2);
        tbl[11] = mk(1, 4'b0100, 32'h0055_0000, 4'b0000, 8'h44, 0, 2'd2);
        tbl[12] = mk(1, 4'b0011, 32'hD4C3_B2A1, 4'b0001, 8'h44, 1, 2'd0);
        tbl[13] = mk(1, 4'b0011, 32'h0000_0201, 4'b0001, 8'h01, 1, 2'd0);
        tbl[14] = mk(1, 4'b0010, 32'h0000_0203, 4'b0000, 8'h01, 1, 2'd0);
        tbl[15] = mk(1, 4'b0010, 32'h0000_0000, 4'b0000, 8'h01, 0, 2'd0);
        tbl[16] = mk(1, 4'b0010, 32'h0000_5A00, 4'b0010, 8'h01, 1, 2'd1);
        tbl[17] = mk(1, 4'b1010, 32'hFF00_6100, 4'b0010, 8'h61, 1, 2'd1);
        tbl[18] = mk(1, 4'b0010, 32'h0000_6200, 4'b0010, 8'h62, 1, 2'd1);
        tbl[19] = mk(1, 4'b0000, 32'h0000_6300, 4'b0000, 8'h62, 1, 2'd1);
        tbl[20] = mk(1, 4'b0000, 32'h0000_0000, 4'b0000, 8'h62, 0, 2'd1);
        tbl[0].req = 4'($urandom);

        for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("table[%0d]", i));

        // round-robin with all four requesting: order 0,1,2,3,0, each MAX_HOLD writes
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
        step(mk(0, 4'hF, 32'h0, 4'b0000, 8'h00, 0, 2'd3), "rr_reset");
        qexp = 8'h00;
        cyc  = 0;
        for (int gi = 0; gi < 5; gi++) begin
            g  = order[gi];
            oh = 4'b0001 << g;
            step(mk(1, 4'hF, rr_data(cyc), oh, qexp, 1, g), $sformatf("rr_grant[%0d]", gi));
            cyc++;
            for (int w = 1; w <= MAX_HOLD; w++) begin
                d    = rr_data(cyc);
                qexp = d[g*8 +: 8];
                step(mk(1, 4'hF, d, (w == MAX_HOLD) ? 4'b0000 : oh, qexp, 1, g),
                     $sformatf("rr_write[%0d.%0d]", gi, w));
                cyc++;
            end
            step(mk(1, 4'hF, rr_data(cyc), 4'b0000, qexp, 0, g), $sformatf("rr_idle[%0d]", gi));
            cyc++;
        end

        // reset dropped asynchronously during the second GRANT cycle
        step(mk(0, 4'hF, 32'h4433_2211, 4'b0000, 8'h00, 0, 2'd3), "mid_pre_reset");
        step(mk(1, 4'hF, 32'h4433_2211, 4'b0001, 8'h00, 1, 2'd0), "mid_grant");
        step(mk(1, 4'hF, 32'h4433_2211, 4'b0001, 8'h11, 1, 2'd0), "mid_write1");
        @(negedge clk);
        reset = 1'b0;
        sb.push_back(mk(0, 4'hF, 32'h4433_2211, 4'b0000, 8'h00, 0, 2'd3));
        #1;
        check_out("mid_async_clear");
        step(mk(0, 4'hF, 32'h4433_2211, 4'b0000, 8'h00, 0, 2'd3), "mid_held_reset");
        step(mk(1, 4'hF, 32'h4433_2277, 4'b0001, 8'h00, 1, 2'd0), "mid_regrant");
        step(mk(1, 4'hF, 32'h4433_2288, 4'b0001, 8'h88, 1, 2'd0), "mid_rewrite");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
